param_cache: RTL and testbench

PARAM_CACHE -- requirements
Module: param_cache

---
 rtl/param_cache_if.sv | 40 ++++
 rtl/param_cache.sv | 162 ++++++++++++++++
 tb/tb_param_cache.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/param_cache_if.sv
// param_cache_if: CPU request, memory read/write and statistics signals of param_cache
interface param_cache_if #(
    parameter int LINE_WORDS = 4
);
    logic                    valid;
    logic                    op;
    logic                    uncached;
    logic [31:0]             addr;
    logic [3:0]              wstrb;
    logic [31:0]             wdata;
    logic                    addr_ok;
    logic                    data_ok;
    logic [31:0]             rdata;
    logic                    rd_req;
    logic [2:0]              rd_type;
    logic [31:0]             rd_addr;
    logic                    rd_rdy;
    logic                    ret_valid;
    logic                    ret_last;
    logic [31:0]             ret_data;
    logic                    wr_req;
    logic [2:0]              wr_type;
    logic [31:0]             wr_addr;
    logic [3:0]              wr_wstrb;
    logic [LINE_WORDS*32-1:0] wr_data;
    logic                    wr_rdy;
    logic [31:0]             hit_cnt;
    logic [31:0]             miss_cnt;

    modport slave (
        input  valid, op, uncached, addr, wstrb, wdata, rd_rdy, ret_valid, ret_last, ret_data, wr_rdy,
        output addr_ok, data_ok, rdata, rd_req, rd_type, rd_addr, wr_req, wr_type, wr_addr, wr_wstrb,
               wr_data, hit_cnt, miss_cnt
    );
    modport master (
        output valid, op, uncached, addr, wstrb, wdata, rd_rdy, ret_valid, ret_last, ret_data, wr_rdy,
        input  addr_ok, data_ok, rdata, rd_req, rd_type, rd_addr, wr_req, wr_type, wr_addr, wr_wstrb,
               wr_data, hit_cnt, miss_cnt
    );
endinterface

// File: rtl/param_cache.sv
// param_cache: blocking set-associative write-back cache with uncached bypass and hit/miss counters
module param_cache #(
    parameter int NUM_WAYS   = 2,
    parameter int INDEX_W    = 8,
    parameter int LINE_WORDS = 4
) (
    input logic          clk,
    input logic          resetn,
    param_cache_if.slave bus
);
    localparam int SETS   = 1 << INDEX_W;
    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam int OFF_W  = WORD_W + 2;
    localparam int TAG_W  = 32 - INDEX_W - OFF_W;
    localparam int WAY_W  = NUM_WAYS > 1 ? $clog2(NUM_WAYS) : 1;

    typedef enum logic [2:0] {IDLE, LOOKUP, MISS, REPLACE, REFILL, RESPOND} state_t;
    state_t state_q, state_d;

    logic [TAG_W-1:0]                 tag_q  [NUM_WAYS][SETS];
    logic [31:0]                      data_q [NUM_WAYS][SETS][LINE_WORDS];
    logic [SETS-1:0][NUM_WAYS-1:0]    valid_q, dirty_q;
    logic [SETS-1:0][WAY_W-1:0]       vptr_q;

    logic                    op_q, unc_q;
    logic [31:0]             addr_q, wdata_q, udata_q, hit_cnt_q, miss_cnt_q;
    logic [3:0]              wstrb_q;
    logic [WAY_W-1:0]        vic_q, vic_d, hit_way;
    logic [WORD_W-1:0]       cnt_q;
    logic                    hit, lk_hit, fill, fill_last;
    logic [INDEX_W-1:0]      idx;
    logic [TAG_W-1:0]        tag;
    logic [WORD_W-1:0]       word;
    logic [LINE_WORDS*32-1:0] line;

    assign idx       = addr_q[OFF_W +: INDEX_W];
    assign tag       = addr_q[31 -: TAG_W];
    assign word      = addr_q[2 +: WORD_W];
    assign lk_hit    = state_q == LOOKUP && !unc_q && hit;
    assign fill      = state_q == REFILL && bus.ret_valid && !unc_q;
    assign fill_last = fill && bus.ret_last;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Tag compare in the latched set; descending scan so the lowest invalid way wins as victim
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        vic_d   = vptr_q[idx];
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (valid_q[idx][w] && tag_q[w][idx] == tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[idx][w]) vic_d = WAY_W'(w);
        end
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.valid) state_d = LOOKUP;
            LOOKUP:  state_d = unc_q ? (op_q ? MISS : REPLACE) : hit ? IDLE :
                               (valid_q[idx][vic_d] && dirty_q[idx][vic_d]) ? MISS : REPLACE;
            MISS:    if (bus.wr_rdy) state_d = unc_q ? RESPOND : REPLACE;
            REPLACE: if (bus.rd_rdy) state_d = REFILL;
            REFILL:  if (bus.ret_valid && bus.ret_last) state_d = RESPOND;
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs; addr_ok is gated by resetn so it stays low while reset is held
    always_comb begin
        line = '0;
        for (int w = 0; w < LINE_WORDS; w++) line[32*w +: 32] = data_q[vic_q][idx][w];
        bus.addr_ok  = resetn && state_q == IDLE;
        bus.data_ok  = lk_hit || state_q == RESPOND;
        bus.rdata    = (lk_hit && !op_q) ? data_q[hit_way][idx][word] :
                       (state_q == RESPOND && !op_q) ? (unc_q ? udata_q : data_q[vic_q][idx][word]) : '0;
        bus.rd_req   = state_q == REPLACE;
        bus.rd_type  = unc_q ? 3'b010 : 3'b100;
        bus.rd_addr  = unc_q ? addr_q : {addr_q[31:OFF_W], {OFF_W{1'b0}}};
        bus.wr_req   = state_q == MISS;
        bus.wr_type  = unc_q ? 3'b010 : 3'b100;
        bus.wr_addr  = unc_q ? addr_q : {tag_q[vic_q][idx], idx, {OFF_W{1'b0}}};
        bus.wr_wstrb = unc_q ? wstrb_q : 4'hf;
        bus.wr_data  = unc_q ? {{(LINE_WORDS-1)*32{1'b0}}, wdata_q} : line;
        bus.hit_cnt  = hit_cnt_q;
        bus.miss_cnt = miss_cnt_q;
    end

    // Request capture, victim latch, refill beat counter, uncached return word and statistics
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_q       <= 1'b0;
            unc_q      <= 1'b0;
            addr_q     <= '0;
            wstrb_q    <= '0;
            wdata_q    <= '0;
            vic_q      <= '0;
            cnt_q      <= '0;
            udata_q    <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (bus.addr_ok && bus.valid) begin
                op_q    <= bus.op;
                unc_q   <= bus.uncached;
                addr_q  <= bus.addr;
                wstrb_q <= bus.wstrb;
                wdata_q <= bus.wdata;
            end
            if (state_q == LOOKUP) begin
                vic_q <= vic_d;
                if (!unc_q) begin
                    hit_cnt_q  <= hit_cnt_q + 32'(hit);
                    miss_cnt_q <= miss_cnt_q + 32'(!hit);
                end
            end
            if (state_q == REPLACE) cnt_q <= '0;
            if (state_q == REFILL && bus.ret_valid) begin
                cnt_q   <= cnt_q + WORD_W'(1);
                udata_q <= bus.ret_data;
            end
        end
    end

    // Valid/dirty/victim-pointer bookkeeping; a line only becomes valid on its last refill beat
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= '0;
            dirty_q <= '0;
            vptr_q  <= '0;
        end else if (lk_hit && op_q) begin
            dirty_q[idx][hit_way] <= 1'b1;
        end else if (fill_last) begin
            valid_q[idx][vic_q] <= 1'b1;
            dirty_q[idx][vic_q] <= op_q;
            vptr_q[idx]         <= vptr_q[idx] == WAY_W'(NUM_WAYS - 1) ? '0 : vptr_q[idx] + WAY_W'(1);
        end
    end

    // Tag and line storage: write hits and refill beats, merging write-miss data at the requested word
    always_ff @(posedge clk) begin
        if (lk_hit && op_q) data_q[hit_way][idx][word] <= merge(data_q[hit_way][idx][word], wdata_q, wstrb_q);
        if (fill) data_q[vic_q][idx][cnt_q] <= (op_q && cnt_q == word) ? merge(bus.ret_data, wdata_q, wstrb_q) : bus.ret_data;
        if (fill_last) tag_q[vic_q][idx] <= tag;
    end
endmodule

// File: tb/tb_param_cache.sv
// tb_param_cache: table-driven transactions against a stalling memory model, plus reset corner cases
module tb_param_cache;
    localparam int LW       = 4;
    localparam int RD_STALL = 2;
    localparam int WR_STALL = 3;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    param_cache_if #(.LINE_WORDS(LW)) bus ();
    param_cache #(.NUM_WAYS(2), .INDEX_W(8), .LINE_WORDS(LW)) dut (.clk(clk), .resetn(resetn), .bus(bus));

    typedef struct {
        string        name;
        logic         op, unc;
        logic [31:0]  addr;
        logic [3:0]   wstrb;
        logic [31:0]  wdata, rdata;
        int           lat, hits, misses, rds;
        logic [2:0]   rtype;
        logic [31:0]  raddr;
        int           wrs;
        logic [2:0]   wtype;
        logic [31:0]  waddr;
        logic [3:0]   wwstrb;
        logic [127:0] wline;
    } vec_t;

    int checks = 0;
    int errors = 0;
    bit auto_mem = 1'b1;
    int rd_cnt = 0, wr_cnt = 0, rd_hold = 0, wr_hold = 0;
    logic [31:0]  last_rd_addr, last_wr_addr;
    logic [2:0]   last_rd_type, last_wr_type;
    logic [3:0]   last_wr_strb;
    logic [127:0] last_wr_data;
    logic [31:0]  mem [logic [31:0]];
    vec_t vecs[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : {16'hD000, a[15:0]};
    endfunction

    function automatic vec_t mk(input string nm, input logic op, input logic unc, input logic [31:0] addr,
                                input logic [3:0] ws, input logic [31:0] wd, input logic [31:0] rd, input int lat,
                                input int h, input int m, input int rds, input logic [2:0] rt, input logic [31:0] ra,
                                input int wrs, input logic [2:0] wt, input logic [31:0] wa, input logic [3:0] wst,
                                input logic [127:0] wl);
        vec_t v;
        v.name = nm; v.op = op; v.unc = unc; v.addr = addr; v.wstrb = ws; v.wdata = wd; v.rdata = rd;
        v.lat = lat; v.hits = h; v.misses = m; v.rds = rds; v.rtype = rt; v.raddr = ra;
        v.wrs = wrs; v.wtype = wt; v.waddr = wa; v.wwstrb = wst; v.wline = wl;
        return v;
    endfunction

    // Memory model: stalls each request, then returns beats or absorbs the write
    initial begin
        int n;
        bus.rd_rdy = 1'b0; bus.ret_valid = 1'b0; bus.ret_last = 1'b0; bus.ret_data = '0; bus.wr_rdy = 1'b0;
        forever begin
            @(negedge clk);
            if (auto_mem && bus.rd_req) begin
                last_rd_addr = bus.rd_addr;
                last_rd_type = bus.rd_type;
                rd_hold = 1;
                for (int i = 0; i < RD_STALL; i++) begin
                    @(negedge clk);
                    if (bus.rd_req) rd_hold++;
                end
                bus.rd_rdy = 1'b1;
                @(negedge clk);
                bus.rd_rdy = 1'b0;
                n = last_rd_type == 3'b100 ? LW : 1;
                for (int i = 0; i < n; i++) begin
                    bus.ret_valid = 1'b1;
                    bus.ret_last  = i == n - 1;
                    bus.ret_data  = mem_rd(last_rd_addr + 32'(4 * i));
                    @(negedge clk);
                end
                bus.ret_valid = 1'b0;
                bus.ret_last  = 1'b0;
                rd_cnt++;
            end else if (auto_mem && bus.wr_req) begin
                last_wr_addr = bus.wr_addr;
                last_wr_type = bus.wr_type;
                last_wr_strb = bus.wr_wstrb;
                last_wr_data = bus.wr_data;
                wr_hold = 1;
                for (int i = 0; i < WR_STALL; i++) begin
                    @(negedge clk);
                    if (bus.wr_req) wr_hold++;
                end
                bus.wr_rdy = 1'b1;
                @(negedge clk);
                bus.wr_rdy = 1'b0;
                if (last_wr_type == 3'b100)
                    for (int i = 0; i < LW; i++) mem[last_wr_addr + 32'(4 * i)] = last_wr_data[32*i +: 32];
                else
                    mem[last_wr_addr] = bmerge(mem_rd(last_wr_addr), last_wr_data[31:0], last_wr_strb);
                wr_cnt++;
            end
        end
    end

    task automatic run(input vec_t v);
        int cyc, rd0, wr0;
        bit done;
        logic [31:0] rd;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        rd = '0;
        @(negedge clk);
        cyc = 0;
        while (!bus.addr_ok && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        bus.valid = 1'b1; bus.op = v.op; bus.uncached = v.unc; bus.addr = v.addr; bus.wstrb = v.wstrb; bus.wdata = v.wdata;
        cyc = 0;
        done = 1'b0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            if (cyc == 0) bus.valid = 1'b0;
            cyc++;
            if (bus.data_ok) begin
                done = 1'b1;
                rd = bus.rdata;
            end
        end
        chk({v.name, " data_ok seen"}, 128'(done), 128'(1));
        @(negedge clk);
        if (!v.op) chk({v.name, " rdata"}, 128'(rd), 128'(v.rdata));
        if (v.lat > 0) chk({v.name, " latency"}, 128'(cyc), 128'(v.lat));
        chk({v.name, " hit_cnt"}, 128'(bus.hit_cnt), 128'(v.hits));
        chk({v.name, " miss_cnt"}, 128'(bus.miss_cnt), 128'(v.misses));
        chk({v.name, " rd reqs"}, 128'(rd_cnt - rd0), 128'(v.rds));
        chk({v.name, " wr reqs"}, 128'(wr_cnt - wr0), 128'(v.wrs));
        if (v.rds > 0) begin
            chk({v.name, " rd_addr"}, 128'(last_rd_addr), 128'(v.raddr));
            chk({v.name, " rd_type"}, 128'(last_rd_type), 128'(v.rtype));
            chk({v.name, " rd_req held"}, 128'(rd_hold), 128'(RD_STALL + 1));
        end
        if (v.wrs > 0) begin
            chk({v.name, " wr_addr"}, 128'(last_wr_addr), 128'(v.waddr));
            chk({v.name, " wr_type"}, 128'(last_wr_type), 128'(v.wtype));
            chk({v.name, " wr_wstrb"}, 128'(last_wr_strb), 128'(v.wwstrb));
            chk({v.name, " wr_req held"}, 128'(wr_hold), 128'(WR_STALL + 1));
            if (v.unc) chk({v.name, " wr_data word"}, 128'(last_wr_data[31:0]), v.wline);
            else       chk({v.name, " wr_data line"}, last_wr_data, v.wline);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " addr_ok"}, 128'(bus.addr_ok), 128'(0));
        chk({tag, " data_ok"}, 128'(bus.data_ok), 128'(0));
        chk({tag, " rd_req"}, 128'(bus.rd_req), 128'(0));
        chk({tag, " wr_req"}, 128'(bus.wr_req), 128'(0));
        chk({tag, " rdata"}, 128'(bus.rdata), 128'(0));
        chk({tag, " hit_cnt"}, 128'(bus.hit_cnt), 128'(0));
        chk({tag, " miss_cnt"}, 128'(bus.miss_cnt), 128'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        bus.valid = 1'b0; bus.op = 1'b0; bus.uncached = 1'b0; bus.addr = '0; bus.wstrb = '0; bus.wdata = '0;
        mem[32'h1000] = 32'h11; mem[32'h1004] = 32'h22; mem[32'h1008] = 32'h33; mem[32'h100C] = 32'h44;

        vecs.push_back(mk("cold rd 1004",   0, 0, 32'h1004, 4'h0, 0, 32'h22,       0, 0, 1, 1, 3'b100, 32'h1000, 0, 0, 0, 0, 0));
        vecs.push_back(mk("hit rd 1004",    0, 0, 32'h1004, 4'h0, 0, 32'h22,       1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("hit wr 1004",    1, 0, 32'h1004, 4'h3, 32'hAABBCCDD, 0, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("rd merged 1004", 0, 0, 32'h1004, 4'h0, 0, 32'h0000CCDD, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("hit rd 100C",    0, 0, 32'h100C, 4'h0, 0, 32'h44,       1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("unc rd 1004",    0, 1, 32'h1004, 4'h0, 0, 32'h22,       0, 4, 1, 1, 3'b010, 32'h1004, 0, 0, 0, 0, 0));
        vecs.push_back(mk("fill 2008",      0, 0, 32'h2008, 4'h0, 0, 32'hD0002008, 0, 4, 2, 1, 3'b100, 32'h2000, 0, 0, 0, 0, 0));
        vecs.push_back(mk("evict rd 3000",  0, 0, 32'h3000, 4'h0, 0, 32'hD0003000, 0, 4, 3, 1, 3'b100, 32'h3000,
                          1, 3'b100, 32'h1000, 4'hf, 128'h00000044_00000033_0000CCDD_00000011));
        vecs.push_back(mk("refetch 1004",   0, 0, 32'h1004, 4'h0, 0, 32'h0000CCDD, 0, 4, 4, 1, 3'b100, 32'h1000, 0, 0, 0, 0, 0));
        vecs.push_back(mk("wr miss 2004",   1, 0, 32'h2004, 4'hC, 32'h12345678, 0, 0, 4, 5, 1, 3'b100, 32'h2000, 0, 0, 0, 0, 0));
        vecs.push_back(mk("rd 2004 merged", 0, 0, 32'h2004, 4'h0, 0, 32'h12342004, 1, 5, 5, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("unc wr 1008",    1, 1, 32'h1008, 4'h6, 32'hCAFEF00D, 0, 0, 5, 5, 0, 0, 0,
                          1, 3'b010, 32'h1008, 4'h6, 128'hCAFEF00D));
        vecs.push_back(mk("unc rd 1008",    0, 1, 32'h1008, 4'h0, 0, 32'h00FEF033, 0, 5, 5, 1, 3'b010, 32'h1008, 0, 0, 0, 0, 0));
        vecs.push_back(mk("stale hit 1008", 0, 0, 32'h1008, 4'h0, 0, 32'h33,       1, 6, 5, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("fill 5000",      0, 0, 32'h5000, 4'h0, 0, 32'hD0005000, 0, 6, 6, 1, 3'b100, 32'h5000, 0, 0, 0, 0, 0));
        vecs.push_back(mk("evict wr-miss",  0, 0, 32'h6000, 4'h0, 0, 32'hD0006000, 0, 6, 7, 1, 3'b100, 32'h6000,
                          1, 3'b100, 32'h2000, 4'hf, 128'hD000200C_D0002008_12342004_D0002000));

        repeat (3) @(negedge clk);
        chk_quiet("in reset");
        resetn = 1'b1;
        #1;
        chk("addr_ok after release", 128'(bus.addr_ok), 128'(1));

        foreach (vecs[i]) run(vecs[i]);

        auto_mem = 1'b0;
        @(negedge clk);
        bus.valid = 1'b1; bus.op = 1'b0; bus.uncached = 1'b0; bus.addr = 32'h1004;
        @(negedge clk);
        bus.valid = 1'b0;
        cyc = 0;
        while (!bus.rd_req && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("abort rd_req seen", 128'(bus.rd_req), 128'(1));
        bus.rd_rdy = 1'b1;
        @(negedge clk);
        bus.rd_rdy = 1'b0;
        bus.ret_valid = 1'b1; bus.ret_last = 1'b0; bus.ret_data = 32'h11;
        @(negedge clk);
        bus.ret_data = 32'h22;
        #1 resetn = 1'b0;
        #1 chk_quiet("reset mid-refill");
        bus.ret_valid = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("addr_ok after mid-refill reset", 128'(bus.addr_ok), 128'(1));
        auto_mem = 1'b1;
        run(mk("post-abort rd 1004", 0, 0, 32'h1004, 4'h0, 0, 32'h0000CCDD, 0, 0, 1, 1, 3'b100, 32'h1000, 0, 0, 0, 0, 0));
        run(mk("post-abort hit",     0, 0, 32'h1004, 4'h0, 0, 32'h0000CCDD, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
